// File: rtl/klein_pkg.sv
// rtl/klein_pkg.sv - KLEIN-80 key schedule types, constants and step functions
// Shared with the encryption-side schedule so forward and inverse stay bit-consistent.
package klein_pkg;

   localparam int KEY_W = 80;
   localparam int RND_W = 8;

   localparam logic [3:0] SBOX [16] = '{
      4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
      4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_EMIT
   } state_t;

   typedef enum logic {
      STEP_FWD,
      STEP_INV
   } step_mode_t;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [39:0] rotl8_40(input logic [39:0] x);
      return {x[31:0], x[39:32]};
   endfunction

   function automatic logic [39:0] rotr8_40(input logic [39:0] x);
      return {x[7:0], x[39:8]};
   endfunction

   // The S-box is an involution, so the same nibble substitution serves both directions.
   function automatic logic [39:0] sub_mid(input logic [39:0] x);
      logic [39:0] y;
      y = x;
      y[31:28] = sbox4(x[31:28]);
      y[27:24] = sbox4(x[27:24]);
      y[23:20] = sbox4(x[23:20]);
      y[19:16] = sbox4(x[19:16]);
      return y;
   endfunction

   function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                                input logic [RND_W-1:0] r);
      logic [39:0] a_r;
      logic [39:0] b_r;
      logic [39:0] hi;
      a_r = rotl8_40(k[79:40]);
      b_r = rotl8_40(k[39:0]);
      hi = b_r;
      hi[23:16] = hi[23:16] ^ r;
      return {hi, sub_mid(a_r ^ b_r)};
   endfunction

   function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] o,
                                                input logic [RND_W-1:0] r);
      logic [39:0] a1;
      logic [39:0] b1;
      b1 = sub_mid(o[39:0]);
      a1 = o[79:40];
      a1[23:16] = a1[23:16] ^ r;
      return {rotr8_40(b1 ^ a1), rotr8_40(a1)};
   endfunction

endpackage

// File: rtl/klein_key_step.sv
// rtl/klein_key_step.sv - combinational KLEIN-80 key schedule step, forward or inverse
module klein_key_step
   import klein_pkg::*;
(
   input  step_mode_t        mode,
   input  logic [RND_W-1:0]  rnd,
   input  logic [KEY_W-1:0]  key,
   output logic [KEY_W-1:0]  key_next
);

   always_comb begin
      key_next = key;
      if (mode == STEP_INV) key_next = key_inv(key, rnd);
      else                  key_next = key_fwd(key, rnd);
   end

endmodule

// File: rtl/klein_key_rev.sv
// rtl/klein_key_rev.sv - KLEIN-80 decryption key scheduler, emits sk[NR+1] down to sk[1]
// Expands forward one round per cycle, then walks back with the inverse step per accepted key.
module klein_key_rev
   import klein_pkg::*;
#(
   parameter int NR = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [KEY_W-1:0]  key_in,
   output logic              busy,
   output logic              rk_valid,
   input  logic              rk_ready,
   output logic [KEY_W-1:0]  rk_data,
   output logic [4:0]        rk_idx,
   output logic              done
);

   localparam logic [4:0] NR_C = 5'(NR);

   state_t           state;
   logic [KEY_W-1:0] key_reg;
   logic [4:0]       cnt;
   logic [4:0]       idx;
   logic [4:0]       round_sel;
   logic [RND_W-1:0] rnd;
   step_mode_t       mode;
   logic [KEY_W-1:0] step_out;

   // Forward uses the expansion counter; inverse undoes round idx-1 to reach sk[idx-1].
   assign round_sel = (state == ST_EMIT) ? (idx - 5'd1) : cnt;
   assign rnd       = {3'b000, round_sel};
   assign mode      = (state == ST_EMIT) ? STEP_INV : STEP_FWD;

   klein_key_step u_step (
      .mode     (mode),
      .rnd      (rnd),
      .key      (key_reg),
      .key_next (step_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         key_reg  <= '0;
         cnt      <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  key_reg <= key_in;
                  cnt     <= 5'd1;
                  busy    <= 1'b1;
                  state   <= ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               key_reg <= step_out;
               cnt     <= cnt + 5'd1;
               if (cnt == NR_C) begin
                  idx      <= NR_C + 5'd1;
                  rk_valid <= 1'b1;
                  state    <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (rk_ready) begin
                  if (idx > 5'd1) begin
                     key_reg <= step_out;
                     idx     <= idx - 5'd1;
                  end else begin
                     idx      <= '0;
                     rk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rk_data = key_reg;
   assign rk_idx  = idx;

endmodule

// File: tb/tb_klein_key_rev.sv
// tb/tb_klein_key_rev.sv - self-checking bench for klein_key_rev
module tb_klein_key_rev;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, rk_ready;
   logic [79:0] key_in;
   logic        busy, rk_valid, done;
   logic [79:0] rk_data;
   logic [4:0]  rk_idx;

   logic        start1, rk_ready1;
   logic [79:0] key_in1;
   logic        busy1, rk_valid1, done1;
   logic [79:0] rk_data1;
   logic [4:0]  rk_idx1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   klein_key_rev #(.NR(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx), .done(done)
   );

   klein_key_rev #(.NR(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key_in1), .busy(busy1),
      .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk_data(rk_data1), .rk_idx(rk_idx1), .done(done1)
   );

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] m_sbox(input logic [3:0] x);
      logic [63:0] t;
      t = 64'h74A91FB0C3268ED5;
      return t[(15 - int'(x)) * 4 +: 4];
   endfunction

   function automatic logic [39:0] m_sub(input logic [39:0] x);
      logic [39:0] y;
      y = x;
      for (int n = 4; n < 8; n++) y[n*4 +: 4] = m_sbox(x[n*4 +: 4]);
      return y;
   endfunction

   function automatic logic [79:0] m_fwd(input logic [79:0] k, input int r);
      logic [39:0] a, b, ar, br, hi;
      a  = k[79:40];
      b  = k[39:0];
      ar = (a << 8) | (a >> 32);
      br = (b << 8) | (b >> 32);
      hi = br ^ (40'(r & 255) << 16);
      return {hi, m_sub(ar ^ br)};
   endfunction

   function automatic logic [79:0] m_inv(input logic [79:0] o, input int r);
      logic [39:0] hi, lo, x;
      lo = m_sub(o[39:0]);
      hi = o[79:40] ^ (40'(r & 255) << 16);
      x  = lo ^ hi;
      return {(x >> 8) | (x << 32), (hi >> 8) | (hi << 32)};
   endfunction

   function automatic logic [79:0] rnd80();
      return {32'($urandom), 32'($urandom), 16'($urandom)};
   endfunction

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, 80'(busy), 80'(0));
      chk({nm, "_valid"}, 80'(rk_valid), 80'(0));
      chk({nm, "_done"}, 80'(done), 80'(0));
      chk({nm, "_data"}, rk_data, 80'(0));
      chk({nm, "_idx"}, 80'(rk_idx), 80'(0));
   endtask

   // Caller is positioned 1 time unit after a rising edge; returns at the same phase.
   task automatic stream16(input logic [79:0] k, input bit bp, input bit inject);
      logic [79:0] sk [1:17];
      logic [79:0] hd;
      logic [4:0]  hx;
      int n, e, hs, low, cyc;
      bit rdy;
      sk[1] = k;
      for (int i = 1; i <= 16; i++) sk[i+1] = m_fwd(sk[i], i);
      start = 1'b1;
      key_in = k;
      @(posedge clk); #1;
      chk("busy_after_start", 80'(busy), 80'(1));
      start = inject;
      key_in = ~k;
      n = 1;
      while (!rk_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("first_valid_edges", 80'(n), 80'(17));
      e = 17; hs = 0; low = 0; cyc = 0;
      while (e >= 1 && cyc < 400) begin
         if (!bp) rdy = 1'b1;
         else if (low > 0) begin rdy = 1'b0; low--; end
         else if ($urandom_range(0, 7) == 0) begin rdy = 1'b0; low = 4; end
         else rdy = ($urandom_range(0, 3) != 0);
         rk_ready = rdy;
         if (inject) key_in = rnd80();
         chk("valid_in_emit", 80'(rk_valid), 80'(1));
         if (rdy) begin
            chk("emit_data", rk_data, sk[e]);
            chk("emit_idx", 80'(rk_idx), 80'(e));
            e--;
            hs++;
         end else begin
            hd = rk_data;
            hx = rk_idx;
         end
         @(posedge clk); #1;
         cyc++;
         if (!rdy) begin
            chk("hold_data", rk_data, hd);
            chk("hold_idx", 80'(rk_idx), 80'(hx));
         end
      end
      start = 1'b0;
      chk("handshakes", 80'(hs), 80'(17));
      chk("done_pulse", 80'(done), 80'(1));
      chk("busy_end", 80'(busy), 80'(0));
      chk("valid_end", 80'(rk_valid), 80'(0));
   endtask

   typedef struct {
      logic [79:0] key;
      logic [79:0] exp2;
   } vec_t;

   initial begin
      vec_t tbl [6];
      logic [79:0] k, r2;
      int n, r;

      rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
      start1 = 1'b0; rk_ready1 = 1'b1; key_in1 = '0;
      @(posedge clk); @(posedge clk); #1;
      chk_zero("reset");
      chk("reset1_valid", 80'(rk_valid1), 80'(0));
      chk("reset1_busy", 80'(busy1), 80'(0));
      rst_n = 1'b1;

      // Model and package self-consistency
      for (int i = 0; i < 1000; i++) begin
         k = rnd80();
         r = int'($urandom_range(0, 255));
         r2 = m_fwd(k, r);
         chk("model_inv_fwd", m_inv(r2, r), k);
         chk("pkg_fwd_vs_model", klein_pkg::key_fwd(k, 8'(r)), r2);
      end

      // NR=1 table
      tbl[0].key = '0;       tbl[0].exp2 = 80'h0000_0100_0000_7777_0000;
      tbl[1].key = '1;       tbl[1].exp2 = 80'hFFFF_FEFF_FF00_7777_0000;
      for (int i = 2; i < 6; i++) begin
         tbl[i].key = rnd80();
         tbl[i].exp2 = m_fwd(tbl[i].key, 1);
      end
      for (int i = 0; i < 6; i++) begin
         start1 = 1'b1; key_in1 = tbl[i].key;
         @(posedge clk); #1;
         start1 = 1'b0;
         chk("nr1_valid_c1", 80'(rk_valid1), 80'(0));
         @(posedge clk); #1;
         chk("nr1_valid_c2", 80'(rk_valid1), 80'(1));
         chk("nr1_idx2", 80'(rk_idx1), 80'(2));
         chk("nr1_data2", rk_data1, tbl[i].exp2);
         @(posedge clk); #1;
         chk("nr1_idx1", 80'(rk_idx1), 80'(1));
         chk("nr1_data1", rk_data1, tbl[i].key);
         @(posedge clk); #1;
         chk("nr1_done", 80'(done1), 80'(1));
         chk("nr1_busy", 80'(busy1), 80'(0));
         @(posedge clk); #1;
         chk("nr1_done_once", 80'(done1), 80'(0));
      end

      for (int i = 0; i < 100; i++) begin
         stream16(rnd80(), 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      for (int i = 0; i < 20; i++) begin
         stream16(rnd80(), 1'b1, 1'b0);
         @(posedge clk); #1;
      end
      // start ignored while busy; back-to-back start right after done
      for (int i = 0; i < 5; i++) stream16(rnd80(), 1'b1, 1'b1);
      @(posedge clk); #1;

      // Reset mid-EXPAND
      start = 1'b1; key_in = rnd80();
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_zero("rst_expand");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_zero("rst_expand_idle");
      stream16(rnd80(), 1'b0, 1'b0);
      @(posedge clk); #1;

      // Reset mid-EMIT at idx 9
      rk_ready = 1'b1;
      start = 1'b1; key_in = rnd80();
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (rk_idx != 5'd9 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_idx9", 80'(rk_idx), 80'(9));
      rst_n = 1'b0;
      #1 chk_zero("rst_emit");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_zero("rst_emit_idle");
      stream16(rnd80(), 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
